// File: rtl/connect4_pkg.sv
// connect4_pkg
// Shared types and constants for the Connect-4 move sequencer.
//   game_state_e         : move_controller FSM states
//   LRP_LEFT/RIGHT/PUT   : bit positions inside the one-hot lrp move bus
//   P1/P2                : player encodings
//   DEF_COLS/ROWS/START  : default board geometry and cursor home column
package connect4_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        CHECK     = 2'd2,
        GAME_OVER = 2'd3
    } game_state_e;

    localparam int LRP_LEFT  = 2;
    localparam int LRP_RIGHT = 1;
    localparam int LRP_PUT   = 0;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam int DEF_COLS      = 7;
    localparam int DEF_ROWS      = 6;
    localparam int DEF_START_COL = 3;

endpackage

// File: rtl/move_controller_column_heights.sv
// column_heights
// One saturating fill counter per board column.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear (new game)
//   rd_col     : column whose height is reported
//   rd_height  : pieces already stacked in rd_col
//   full       : rd_col holds ROWS pieces
//   inc_en     : add one piece to inc_col
//   inc_col    : column receiving the piece
module column_heights
    import connect4_pkg::*;
#(
    parameter  int COLS = DEF_COLS,
    parameter  int ROWS = DEF_ROWS,
    localparam int CW   = $clog2(COLS),
    localparam int HW   = $clog2(ROWS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [CW-1:0] rd_col,
    output logic [HW-1:0] rd_height,
    output logic          full,
    input  logic          inc_en,
    input  logic [CW-1:0] inc_col
);

    localparam logic [HW-1:0] ROWS_H = HW'(ROWS);

    logic [HW-1:0] height_r [COLS];
    logic [HW-1:0] rd_height_s;

    for (genvar i = 0; i < COLS; i++) begin : g_col
        // Per-column counter; saturates so a stray increment cannot wrap a full column.
        always_ff @(posedge clk) begin
            if (rst || clr) begin
                height_r[i] <= '0;
            end else if (inc_en && (inc_col == CW'(i)) && (height_r[i] != ROWS_H)) begin
                height_r[i] <= height_r[i] + HW'(1);
            end
        end
    end

    // Read mux; a column index beyond COLS-1 reads as empty.
    always_comb begin
        rd_height_s = '0;
        for (int i = 0; i < COLS; i++) begin
            if (rd_col == CW'(i)) begin
                rd_height_s = height_r[i];
            end else begin
                rd_height_s = rd_height_s;
            end
        end
    end

    assign rd_height = rd_height_s;
    assign full      = (rd_height_s == ROWS_H);

endmodule

// File: rtl/move_controller.sv
// move_controller
// Sequences one Connect-4 move at a time: cursor movement, board write
// (req/ack), win check (req/done), then hands the turn to the other player.
//   clk, rst          : clock, synchronous active-high reset
//   lrp               : one-hot {left, right, put} pulses
//   new_game          : restart request (IDLE / GAME_OVER only)
//   cursor, player    : cursor column, player to move
//   wr_req/row/col/player, wr_ack      : board write handshake
//   chk_req, chk_done, chk_win         : win-check handshake
//   game_over, winner, draw            : game result
module move_controller
    import connect4_pkg::*;
#(
    parameter  int COLS      = DEF_COLS,
    parameter  int ROWS      = DEF_ROWS,
    parameter  int START_COL = DEF_START_COL,
    localparam int CW        = $clog2(COLS),
    localparam int RW        = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    lrp,
    input  logic          new_game,
    output logic [CW-1:0] cursor,
    output logic          player,
    output logic          wr_req,
    output logic [RW-1:0] wr_row,
    output logic [CW-1:0] wr_col,
    output logic          wr_player,
    input  logic          wr_ack,
    output logic          chk_req,
    input  logic          chk_done,
    input  logic          chk_win,
    output logic          game_over,
    output logic          winner,
    output logic          draw
);

    localparam int            HW    = $clog2(ROWS + 1);
    localparam int            MW    = $clog2(ROWS * COLS + 1);
    localparam logic [MW-1:0] CELLS = MW'(ROWS * COLS);

    game_state_e   state_r,     state_s;
    logic [CW-1:0] cursor_r,    cursor_s;
    logic          player_r,    player_s;
    logic          wr_req_r,    wr_req_s;
    logic [RW-1:0] wr_row_r,    wr_row_s;
    logic [CW-1:0] wr_col_r,    wr_col_s;
    logic          wr_player_r, wr_player_s;
    logic          chk_req_r,   chk_req_s;
    logic [MW-1:0] move_cnt_r,  move_cnt_s;
    logic          game_over_r, game_over_s;
    logic          winner_r,    winner_s;
    logic          draw_r,      draw_s;
    logic          clear_s;
    logic          inc_s;
    logic [HW-1:0] col_height_s;
    logic          col_full_s;

    column_heights #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_heights (
        .clk       (clk),
        .rst       (rst),
        .clr       (clear_s),
        .rd_col    (cursor_r),
        .rd_height (col_height_s),
        .full      (col_full_s),
        .inc_en    (inc_s),
        .inc_col   (wr_col_r)
    );

    // Next-state and next-output logic; clear_s requests the reset state for a new game.
    always_comb begin
        state_s     = state_r;
        cursor_s    = cursor_r;
        player_s    = player_r;
        wr_req_s    = wr_req_r;
        wr_row_s    = wr_row_r;
        wr_col_s    = wr_col_r;
        wr_player_s = wr_player_r;
        chk_req_s   = chk_req_r;
        move_cnt_s  = move_cnt_r;
        game_over_s = game_over_r;
        winner_s    = winner_r;
        draw_s      = draw_r;
        clear_s     = 1'b0;
        inc_s       = 1'b0;
        case (state_r)
            IDLE: begin
                // new_game outranks any same-cycle move pulse; left > right > put.
                if (new_game) begin
                    clear_s = 1'b1;
                end else if (lrp[LRP_LEFT]) begin
                    if (cursor_r == '0) begin
                        cursor_s = CW'(COLS - 1);
                    end else begin
                        cursor_s = cursor_r - CW'(1);
                    end
                end else if (lrp[LRP_RIGHT]) begin
                    if (cursor_r == CW'(COLS - 1)) begin
                        cursor_s = '0;
                    end else begin
                        cursor_s = cursor_r + CW'(1);
                    end
                end else if (lrp[LRP_PUT] && !col_full_s) begin
                    // Height is below ROWS here, so it fits the row field.
                    wr_col_s    = cursor_r;
                    wr_row_s    = RW'(col_height_s);
                    wr_player_s = player_r;
                    wr_req_s    = 1'b1;
                    state_s     = WRITE;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                if (wr_ack) begin
                    inc_s      = 1'b1;
                    move_cnt_s = move_cnt_r + MW'(1);
                    wr_req_s   = 1'b0;
                    chk_req_s  = 1'b1;
                    state_s    = CHECK;
                end else begin
                    state_s = WRITE;
                end
            end
            CHECK: begin
                if (chk_done) begin
                    chk_req_s = 1'b0;
                    if (chk_win) begin
                        game_over_s = 1'b1;
                        winner_s    = wr_player_r;
                        state_s     = GAME_OVER;
                    end else if (move_cnt_r == CELLS) begin
                        game_over_s = 1'b1;
                        draw_s      = 1'b1;
                        state_s     = GAME_OVER;
                    end else begin
                        player_s = ~player_r;
                        state_s  = IDLE;
                    end
                end else begin
                    state_s = CHECK;
                end
            end
            GAME_OVER: begin
                if (new_game) begin
                    clear_s = 1'b1;
                end else begin
                    state_s = GAME_OVER;
                end
            end
            default: begin
                state_s   = IDLE;
                wr_req_s  = 1'b0;
                chk_req_s = 1'b0;
            end
        endcase
    end

    // State and output registers; rst and new_game share the same reset image.
    always_ff @(posedge clk) begin
        if (rst || clear_s) begin
            state_r     <= IDLE;
            cursor_r    <= CW'(START_COL);
            player_r    <= P1;
            wr_req_r    <= 1'b0;
            wr_row_r    <= '0;
            wr_col_r    <= '0;
            wr_player_r <= P1;
            chk_req_r   <= 1'b0;
            move_cnt_r  <= '0;
            game_over_r <= 1'b0;
            winner_r    <= 1'b0;
            draw_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cursor_r    <= cursor_s;
            player_r    <= player_s;
            wr_req_r    <= wr_req_s;
            wr_row_r    <= wr_row_s;
            wr_col_r    <= wr_col_s;
            wr_player_r <= wr_player_s;
            chk_req_r   <= chk_req_s;
            move_cnt_r  <= move_cnt_s;
            game_over_r <= game_over_s;
            winner_r    <= winner_s;
            draw_r      <= draw_s;
        end
    end

    assign cursor    = cursor_r;
    assign player    = player_r;
    assign wr_req    = wr_req_r;
    assign wr_row    = wr_row_r;
    assign wr_col    = wr_col_r;
    assign wr_player = wr_player_r;
    assign chk_req   = chk_req_r;
    assign game_over = game_over_r;
    assign winner    = winner_r;
    assign draw      = draw_r;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: a 7x6 board (index 0) and a 2x2 board (index 1)
// run side by side, each followed by a game-level model compared every cycle.
module tb_move_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v      [2];
    logic [2:0] lrp_v      [2];
    logic       new_game_v [2];
    logic       wr_ack_v   [2];
    logic       chk_done_v [2];
    logic       chk_win_v  [2];

    logic [2:0] cursor0, wr_row0, wr_col0;
    logic       player0, wr_req0, wr_player0, chk_req0, game_over0, winner0, draw0;
    logic [0:0] cursor1, wr_row1, wr_col1;
    logic       player1, wr_req1, wr_player1, chk_req1, game_over1, winner1, draw1;

    move_controller #(.COLS(7), .ROWS(6), .START_COL(3)) dut0 (
        .clk(clk), .rst(rst_v[0]), .lrp(lrp_v[0]), .new_game(new_game_v[0]),
        .cursor(cursor0), .player(player0), .wr_req(wr_req0), .wr_row(wr_row0),
        .wr_col(wr_col0), .wr_player(wr_player0), .wr_ack(wr_ack_v[0]),
        .chk_req(chk_req0), .chk_done(chk_done_v[0]), .chk_win(chk_win_v[0]),
        .game_over(game_over0), .winner(winner0), .draw(draw0));

    move_controller #(.COLS(2), .ROWS(2), .START_COL(0)) dut1 (
        .clk(clk), .rst(rst_v[1]), .lrp(lrp_v[1]), .new_game(new_game_v[1]),
        .cursor(cursor1), .player(player1), .wr_req(wr_req1), .wr_row(wr_row1),
        .wr_col(wr_col1), .wr_player(wr_player1), .wr_ack(wr_ack_v[1]),
        .chk_req(chk_req1), .chk_done(chk_done_v[1]), .chk_win(chk_win_v[1]),
        .game_over(game_over1), .winner(winner1), .draw(draw1));

    int checks   = 0;
    int failures = 0;

    // ---------------- game-level model ----------------
    localparam int PH_PLAY = 0;   // waiting for player input
    localparam int PH_WR   = 1;   // board write outstanding
    localparam int PH_CK   = 2;   // win check outstanding
    localparam int PH_END  = 3;   // game finished

    int m_cols  [2] = '{7, 2};
    int m_rows  [2] = '{6, 2};
    int m_start [2] = '{3, 0};
    int m_valid [2] = '{0, 0};
    int m_cursor[2], m_player[2], m_phase[2], m_moves[2];
    int m_row[2], m_col[2], m_wp[2], m_over[2], m_winner[2], m_draw[2];
    int m_h[2][8];

    task automatic model_reset(input int d);
        m_cursor[d] = m_start[d];
        m_player[d] = 0;
        m_phase[d]  = PH_PLAY;
        m_moves[d]  = 0;
        m_over[d]   = 0;
        m_winner[d] = 0;
        m_draw[d]   = 0;
        for (int c = 0; c < 8; c++) m_h[d][c] = 0;
    endtask

    task automatic model_step(input int d);
        if (rst_v[d]) begin
            model_reset(d);
            m_valid[d] = 1;
        end else if (m_valid[d] != 0) begin
            if (m_phase[d] == PH_PLAY) begin
                if (new_game_v[d]) model_reset(d);
                else if (lrp_v[d][2]) m_cursor[d] = (m_cursor[d] + m_cols[d] - 1) % m_cols[d];
                else if (lrp_v[d][1]) m_cursor[d] = (m_cursor[d] + 1) % m_cols[d];
                else if (lrp_v[d][0] && m_h[d][m_cursor[d]] < m_rows[d]) begin
                    m_col[d]   = m_cursor[d];
                    m_row[d]   = m_h[d][m_cursor[d]];
                    m_wp[d]    = m_player[d];
                    m_phase[d] = PH_WR;
                end
            end else if (m_phase[d] == PH_WR) begin
                if (wr_ack_v[d]) begin
                    m_h[d][m_col[d]] += 1;
                    m_moves[d] += 1;
                    m_phase[d] = PH_CK;
                end
            end else if (m_phase[d] == PH_CK) begin
                if (chk_done_v[d]) begin
                    if (chk_win_v[d]) begin
                        m_over[d] = 1; m_winner[d] = m_wp[d]; m_phase[d] = PH_END;
                    end else if (m_moves[d] == m_rows[d] * m_cols[d]) begin
                        m_over[d] = 1; m_draw[d] = 1; m_phase[d] = PH_END;
                    end else begin
                        m_player[d] = 1 - m_player[d]; m_phase[d] = PH_PLAY;
                    end
                end
            end else begin
                if (new_game_v[d]) model_reset(d);
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic cmp(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, d, $time, act, exp);
        end
    endtask

    task automatic cmp_dut(input int d, input int cur, input int ply, input int wrq,
                           input int row, input int col, input int wpl, input int ckq,
                           input int go, input int win, input int dr);
        cmp("cursor", d, cur, m_cursor[d]);
        cmp("player", d, ply, m_player[d]);
        cmp("wr_req", d, wrq, (m_phase[d] == PH_WR) ? 1 : 0);
        cmp("chk_req", d, ckq, (m_phase[d] == PH_CK) ? 1 : 0);
        cmp("game_over", d, go, m_over[d]);
        cmp("winner", d, win, m_winner[d]);
        cmp("draw", d, dr, m_draw[d]);
        if (m_phase[d] == PH_WR || m_phase[d] == PH_CK) begin
            cmp("wr_row", d, row, m_row[d]);
            cmp("wr_col", d, col, m_col[d]);
            cmp("wr_player", d, wpl, m_wp[d]);
        end
    endtask

    // Every-cycle comparison on the inactive edge.
    always @(negedge clk) begin
        if (m_valid[0] != 0)
            cmp_dut(0, int'(cursor0), int'(player0), int'(wr_req0), int'(wr_row0), int'(wr_col0),
                    int'(wr_player0), int'(chk_req0), int'(game_over0), int'(winner0), int'(draw0));
        if (m_valid[1] != 0)
            cmp_dut(1, int'(cursor1), int'(player1), int'(wr_req1), int'(wr_row1), int'(wr_col1),
                    int'(wr_player1), int'(chk_req1), int'(game_over1), int'(winner1), int'(draw1));
    end

    // ---------------- directed stimulus ----------------
    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input int d, input logic [2:0] v);
        lrp_v[d] = v;
        tick();
        lrp_v[d] = 3'b000;
    endtask

    task automatic ng(input int d);
        new_game_v[d] = 1'b1;
        tick();
        new_game_v[d] = 1'b0;
    endtask

    task automatic handshake(input int d, input int ack_dly, input int done_dly, input logic win);
        repeat (ack_dly) tick();
        wr_ack_v[d] = 1'b1;
        tick();
        wr_ack_v[d] = 1'b0;
        repeat (done_dly) tick();
        chk_done_v[d] = 1'b1;
        chk_win_v[d]  = win;
        tick();
        chk_done_v[d] = 1'b0;
        chk_win_v[d]  = 1'b0;
    endtask

    localparam logic [2:0] L = 3'b100, R = 3'b010, P = 3'b001;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1; lrp_v[d] = 3'b000; new_game_v[d] = 1'b0;
            wr_ack_v[d] = 1'b0; chk_done_v[d] = 1'b0; chk_win_v[d] = 1'b0;
        end
        tick(); tick();
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        lit("reset_cursor", int'(cursor0), 3);
        lit("reset_player", int'(player0), 0);
        lit("reset_wr_req", int'(wr_req0), 0);
        lit("reset_game_over", int'(game_over0), 0);

        // Cursor wrap on the 7-wide board.
        pulse(0, L); lit("left1", int'(cursor0), 2);
        pulse(0, L); lit("left2", int'(cursor0), 1);
        pulse(0, L); lit("left3", int'(cursor0), 0);
        pulse(0, L); lit("left_wrap", int'(cursor0), 6);
        pulse(0, R); lit("right_wrap", int'(cursor0), 0);
        repeat (3) pulse(0, R);
        lit("cursor_col3", int'(cursor0), 3);

        // First put at column 3 with a delayed ack.
        pulse(0, P);
        lit("put_wr_req", int'(wr_req0), 1);
        lit("put_wr_row", int'(wr_row0), 0);
        lit("put_wr_col", int'(wr_col0), 3);
        lit("put_wr_player", int'(wr_player0), 0);
        tick(); lit("held_wr_req2", int'(wr_req0), 1);
        tick(); lit("held_wr_req3", int'(wr_req0), 1);
        wr_ack_v[0] = 1'b1; tick(); wr_ack_v[0] = 1'b0;
        lit("ack_wr_req_drop", int'(wr_req0), 0);
        lit("ack_chk_req", int'(chk_req0), 1);
        tick(); lit("chk_req_held", int'(chk_req0), 1);
        chk_done_v[0] = 1'b1; tick(); chk_done_v[0] = 1'b0;
        lit("chk_req_drop", int'(chk_req0), 0);
        lit("player_toggle", int'(player0), 1);
        lit("cursor_kept", int'(cursor0), 3);

        pulse(0, P);
        lit("second_put_row", int'(wr_row0), 1);
        lit("second_put_player", int'(wr_player0), 1);
        handshake(0, 0, 0, 1'b0);

        // Fill column 0, then try a seventh piece.
        repeat (3) pulse(0, L);
        lit("cursor_col0", int'(cursor0), 0);
        for (int i = 0; i < 6; i++) begin
            pulse(0, P);
            lit("fill_row", int'(wr_row0), i);
            handshake(0, 0, 0, 1'b0);
        end
        pulse(0, P);
        lit("full_col_no_req", int'(wr_req0), 0);
        lit("full_col_player", int'(player0), 0);
        tick();
        lit("full_col_still_idle", int'(wr_req0), 0);

        // Pulses during WRITE and CHECK are dropped.
        pulse(0, R);
        pulse(0, P);
        pulse(0, L); pulse(0, R); pulse(0, P);
        lit("write_gate_cursor", int'(cursor0), 1);
        lit("write_gate_req", int'(wr_req0), 1);
        wr_ack_v[0] = 1'b1; tick(); wr_ack_v[0] = 1'b0;
        pulse(0, L); pulse(0, P); ng(0);
        lit("check_gate_chk_req", int'(chk_req0), 1);
        lit("check_gate_cursor", int'(cursor0), 1);
        chk_done_v[0] = 1'b1; tick(); chk_done_v[0] = 1'b0;
        lit("no_second_wr_req", int'(wr_req0), 0);
        lit("gate_player", int'(player0), 1);

        // P2 wins.
        pulse(0, P);
        lit("p2_row", int'(wr_row0), 1);
        lit("p2_player", int'(wr_player0), 1);
        handshake(0, 1, 1, 1'b1);
        lit("win_game_over", int'(game_over0), 1);
        lit("win_winner", int'(winner0), 1);
        lit("win_draw", int'(draw0), 0);
        pulse(0, L); pulse(0, P);
        lit("over_cursor_hold", int'(cursor0), 1);
        lit("over_no_req", int'(wr_req0), 0);
        ng(0);
        lit("ng_cursor", int'(cursor0), 3);
        lit("ng_player", int'(player0), 0);
        lit("ng_game_over", int'(game_over0), 0);
        pulse(0, P);
        lit("ng_height_cleared", int'(wr_row0), 0);
        ng(0);
        lit("ng_in_write_ignored", int'(wr_req0), 1);
        handshake(0, 0, 0, 1'b0);

        // new_game beats a same-cycle left pulse.
        pulse(0, R);
        lit("pre_ng_cursor", int'(cursor0), 4);
        lrp_v[0] = L; new_game_v[0] = 1'b1; tick(); lrp_v[0] = 3'b000; new_game_v[0] = 1'b0;
        lit("ng_wins_cursor", int'(cursor0), 3);
        lit("ng_wins_player", int'(player0), 0);

        // Reset in the middle of a write.
        pulse(0, P);
        rst_v[0] = 1'b1; tick(); rst_v[0] = 1'b0;
        lit("rst_wr_req", int'(wr_req0), 0);
        lit("rst_cursor", int'(cursor0), 3);

        // 2x2 board: four moves without a win end in a draw.
        pulse(1, P);
        lit("b2_row0", int'(wr_row1), 0);
        handshake(1, 0, 0, 1'b0);
        pulse(1, P);
        lit("b2_row1", int'(wr_row1), 1);
        handshake(1, 0, 0, 1'b0);
        pulse(1, R);
        pulse(1, P);
        lit("b2_col1", int'(wr_col1), 1);
        handshake(1, 0, 0, 1'b0);
        lit("b2_not_over_yet", int'(game_over1), 0);
        pulse(1, P);
        handshake(1, 0, 0, 1'b0);
        lit("b2_draw", int'(draw1), 1);
        lit("b2_game_over", int'(game_over1), 1);
        lit("b2_winner", int'(winner1), 0);
        ng(1);
        pulse(1, P);
        rst_v[1] = 1'b1; tick(); rst_v[1] = 1'b0;
        lit("b2_rst_wr_req", int'(wr_req1), 0);
        lit("b2_rst_cursor", int'(cursor1), 0);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/move_controller.md
Name: move_controller

Overview:
- Sequences one Connect-4 move at a time from the player input pulses.
- Keeps the cursor column, per-column fill heights, current player and move count.
- Issues a board write via req/ack handshake, then a win-check via req/done handshake, then alternates player.
- Sits between the debounced one-hot input stage (lrp) and the board memory / win-detector.

Parameters:
COLS, 7, number of board columns (2..8)
ROWS, 6, number of board rows (2..8)
START_COL, 3, cursor column after reset / new game (< COLS)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
lrp  input  3  one-hot move pulses {left, right, put}, 1-cycle each
new_game  input  1  restart request pulse
cursor  output  CW=$clog2(COLS)  current cursor column
player  output  1  player to move (0 = P1, 1 = P2)
wr_req  output  1  board write request, held until wr_ack
wr_row  output  RW=$clog2(ROWS)  row to write (0 = bottom)
wr_col  output  CW  column to write
wr_player  output  1  piece owner for the write
wr_ack  input  1  board write accepted
chk_req  output  1  win-check request, held until chk_done
chk_done  input  1  win-check finished (1 cycle)
chk_win  input  1  win flag, valid with chk_done
game_over  output  1  game finished
winner  output  1  winning player, valid when game_over and !draw
draw  output  1  board full, no winner

Behaviour:
- Single clock domain: clk. rst is synchronous, active-high.
- Reset values: cursor=START_COL, player=0, all heights=0, move count=0, wr_req=0, chk_req=0, game_over=0, winner=0, draw=0, state=IDLE.
- FSM states: IDLE, WRITE, CHECK, GAME_OVER.
- IDLE:
  - lrp[2]: cursor decrements; at 0 it wraps to COLS-1.
  - lrp[1]: cursor increments; at COLS-1 it wraps to 0.
  - Cursor updates one cycle after the pulse.
  - lrp[0] with height[cursor] < ROWS: latch wr_col=cursor, wr_row=height[cursor], wr_player=player; go to WRITE with wr_req=1 on the next cycle.
  - lrp[0] on a full column: ignored; state and outputs unchanged.
  - If lrp is not one-hot, priority is left > right > put.
- WRITE:
  - wr_req, wr_row, wr_col and wr_player are held stable until wr_ack is sampled high.
  - On the wr_ack cycle: height[wr_col]++, move count++, wr_req=0, chk_req=1 next cycle, go to CHECK.
  - wr_ack in the same cycle wr_req first rises is legal. wr_ack while wr_req=0 is ignored.
- CHECK:
  - chk_req is held until chk_done.
  - On chk_done with chk_win=1: game_over=1, winner=wr_player, go to GAME_OVER.
  - On chk_done with chk_win=0 and move count = ROWS*COLS: game_over=1, draw=1, go to GAME_OVER.
  - Otherwise: player toggles, cursor is unchanged, go to IDLE.
  - chk_req drops the cycle after chk_done.
- GAME_OVER:
  - lrp is ignored; outputs hold.
- Input gating:
  - lrp is ignored in WRITE, CHECK and GAME_OVER. There is no queuing; pulses are dropped.
  - The cursor does not move during WRITE or CHECK.
- new_game:
  - Honoured in IDLE and GAME_OVER only. Next cycle equals the reset state.
  - Ignored in WRITE and CHECK, so an in-flight handshake is never abandoned.
  - Same-cycle new_game and lrp in IDLE: new_game wins.
- rst mid-handshake: req outputs drop next cycle; the downstream side must tolerate an abandoned request.
- Move-count width: $clog2(ROWS*COLS+1). Height width: $clog2(ROWS+1).
- Latency: lrp put pulse to wr_req = 1 cycle. Minimum move with immediate ack/done = 4 cycles back to IDLE.

Decomposition:
- Package connect4_pkg:
  - game_state_e enum (IDLE, WRITE, CHECK, GAME_OVER).
  - LRP_LEFT=2, LRP_RIGHT=1, LRP_PUT=0 bit-index constants.
  - P1=1'b0, P2=1'b1.
  - Default COLS/ROWS localparams.
- Sub-module column_heights:
  - Array of COLS saturating counters.
  - Read port at cursor; increment port at wr_col.
  - full flag per read; synchronous clear on rst/new_game.

Test Plan:
- Reset, then 4× left pulses -> cursor 3,2,1,0,6 (wrap). Then 1× right -> cursor 0.
- Put at col 3, wr_ack after 2 cycles -> wr_row=0/wr_col=3/wr_player=0 held for 3 cycles; chk_req=1; chk_done (win=0) -> player=1. Second put at col 3 -> wr_row=1.
- 6 puts into col 0 (ack/done immediate, no win), then 7th put -> no wr_req, state stays IDLE, player unchanged.
- Left/right/put pulses injected during WRITE and CHECK -> cursor and heights unchanged, no second wr_req.
- chk_done with chk_win=1 after P2's write -> game_over=1, winner=1, draw=0. Further lrp ignored. new_game -> cursor=3, player=0, heights=0, game_over=0.
- With ROWS=2, COLS=2, 4 moves and no win -> 4th check gives draw=1, game_over=1. rst asserted during WRITE -> wr_req=0 next cycle, all reset values restored.
